// File: rtl/pixel_line_reader.sv
// Ping-pong line buffer feeding the HDMI encoder: stores DMA words, then unpacks
// RGB565 / 8-bit gray pixels with optional doubling into 24-bit RGB, 2-cycle latency.
module pixel_line_reader #(
    parameter int bankDepthLog2 = 9,
    parameter int maxWidth      = 640
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     bufferWe,
    input  logic [bankDepthLog2-1:0] bufferAddress,
    input  logic [31:0]              bufferData,
    input  logic                     writeIndex,
    input  logic [9:0]               graphicsWidth,
    input  logic                     dualPixel,
    input  logic                     grayscale,
    input  logic                     lineActive,
    input  logic                     lineStart,
    input  logic                     pixelRequest,
    output logic                     pixelValid,
    output logic [7:0]               red,
    output logic [7:0]               green,
    output logic [7:0]               blue
);
    localparam int AW = bankDepthLog2 + 1;
    localparam logic [9:0] MAX_W = 10'(maxWidth);
    localparam logic [9:0] P_MAX = 10'd1023;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   rd_data_q;
    logic [AW-1:0] rd_addr;

    logic       read_bank_q, read_bank_d;
    logic [9:0] width_q, width_d;
    logic       dual_q, dual_d;
    logic       gray_q, gray_d;
    logic       active_q, active_d;
    logic [9:0] p_q, p_d;

    logic       s1_valid_q, s1_blank_q, s1_gray_q;
    logic [1:0] s1_sel_q, s1_sel_d;
    logic       blank_d;
    logic [9:0] eff_p, src;

    logic       valid_q;
    logic [7:0] red_q, green_q, blue_q;
    logic [7:0] red_d, green_d, blue_d;
    logic [15:0] half_word;
    logic [7:0]  gray_byte;

    // Registered read; a same-cycle write to the read address returns the old word.
    always_ff @(posedge clock) begin
        if (bufferWe) begin
            mem[{writeIndex, bufferAddress}] <= bufferData;
        end
        rd_data_q <= mem[rd_addr];
    end

    // A lineStart takes effect for a request in the same cycle, so the
    // effective configuration bypasses the line registers when it is high.
    always_comb begin
        read_bank_d = lineStart ? ~writeIndex : read_bank_q;
        width_d     = lineStart ? ((graphicsWidth > MAX_W) ? MAX_W : graphicsWidth) : width_q;
        dual_d      = lineStart ? dualPixel  : dual_q;
        gray_d      = lineStart ? grayscale  : gray_q;
        active_d    = lineStart ? lineActive : active_q;
        eff_p       = lineStart ? 10'd0 : p_q;
        src         = dual_d ? {1'b0, eff_p[9:1]} : eff_p;
        rd_addr     = {read_bank_d, gray_d ? bankDepthLog2'(src >> 2) : bankDepthLog2'(src >> 1)};
        s1_sel_d    = gray_d ? src[1:0] : {1'b0, src[0]};
        blank_d     = (eff_p >= width_d) || !active_d;
        p_d         = (pixelRequest && eff_p != P_MAX) ? eff_p + 10'd1 : eff_p;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_bank_q <= 1'b1;
            width_q     <= '0;
            dual_q      <= 1'b0;
            gray_q      <= 1'b0;
            active_q    <= 1'b0;
            p_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_blank_q  <= 1'b0;
            s1_gray_q   <= 1'b0;
            s1_sel_q    <= '0;
        end else begin
            read_bank_q <= read_bank_d;
            width_q     <= width_d;
            dual_q      <= dual_d;
            gray_q      <= gray_d;
            active_q    <= active_d;
            p_q         <= p_d;
            s1_valid_q  <= pixelRequest;
            s1_blank_q  <= blank_d;
            s1_gray_q   <= gray_d;
            s1_sel_q    <= s1_sel_d;
        end
    end

    always_comb begin
        half_word = s1_sel_q[0] ? rd_data_q[15:0] : rd_data_q[31:16];
        case (s1_sel_q)
            2'd0:    gray_byte = rd_data_q[31:24];
            2'd1:    gray_byte = rd_data_q[23:16];
            2'd2:    gray_byte = rd_data_q[15:8];
            default: gray_byte = rd_data_q[7:0];
        endcase
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (s1_valid_q && !s1_blank_q) begin
            if (s1_gray_q) begin
                red_d   = gray_byte;
                green_d = gray_byte;
                blue_d  = gray_byte;
            end else begin
                red_d   = {half_word[15:11], half_word[15:13]};
                green_d = {half_word[10:5],  half_word[10:9]};
                blue_d  = {half_word[4:0],   half_word[4:2]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            valid_q <= s1_valid_q;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign pixelValid = valid_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
endmodule

// File: tb/tb_pixel_line_reader.sv
// Scoreboard bench for pixel_line_reader: driver pushes expected pixels from a
// behavioural line-buffer model, a negedge monitor checks every output cycle.
module tb_pixel_line_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bufferWe = 1'b0;
    logic [8:0]  bufferAddress = '0;
    logic [31:0] bufferData = '0;
    logic        writeIndex = 1'b0;
    logic [9:0]  graphicsWidth = '0;
    logic        dualPixel = 1'b0;
    logic        grayscale = 1'b0;
    logic        lineActive = 1'b0;
    logic        lineStart = 1'b0;
    logic        pixelRequest = 1'b0;
    logic        pixelValid;
    logic [7:0]  red, green, blue;

    pixel_line_reader #(.bankDepthLog2(9), .maxWidth(640)) dut (
        .clock(clock), .reset(reset), .bufferWe(bufferWe), .bufferAddress(bufferAddress),
        .bufferData(bufferData), .writeIndex(writeIndex), .graphicsWidth(graphicsWidth),
        .dualPixel(dualPixel), .grayscale(grayscale), .lineActive(lineActive),
        .lineStart(lineStart), .pixelRequest(pixelRequest), .pixelValid(pixelValid),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mem_m [0:1023];
    int m_bank = 1, m_width = 0, m_p = 0;
    bit m_dual = 0, m_gray = 0, m_active = 0;

    typedef struct { int due; logic [23:0] rgb; } exp_t;
    exp_t sb[$];

    function automatic logic [23:0] expect_px(int p);
        int s, v, r5, g6, b5, r, g, b;
        logic [31:0] w;
        if (!m_active || p >= m_width) return 24'h0;
        s = m_dual ? p / 2 : p;
        if (m_gray) begin
            w = mem_m[m_bank * 512 + s / 4];
            v = int'(w >> (8 * (3 - s % 4))) & 255;
            return {v[7:0], v[7:0], v[7:0]};
        end
        w = mem_m[m_bank * 512 + s / 2];
        v = int'(w >> (16 * (1 - s % 2))) & 65535;
        r5 = (v / 2048) % 32;
        g6 = (v / 32) % 64;
        b5 = v % 32;
        r = r5 * 8 + r5 / 4;
        g = g6 * 4 + g6 / 16;
        b = b5 * 8 + b5 / 4;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Applies the currently driven inputs to the model, then clocks the DUT once.
    task automatic step();
        exp_t e;
        exp_t keep[$];
        if (reset) begin
            m_p = 0; m_bank = 1; m_width = 0;
            m_dual = 0; m_gray = 0; m_active = 0;
            foreach (sb[i]) if (sb[i].due > cyc + 2) keep.push_back(sb[i]);
            sb = keep;
        end else begin
            if (lineStart) begin
                m_bank   = writeIndex ? 0 : 1;
                m_width  = (int'(graphicsWidth) > 640) ? 640 : int'(graphicsWidth);
                m_dual   = dualPixel;
                m_gray   = grayscale;
                m_active = lineActive;
                m_p      = 0;
            end
            if (pixelRequest) begin
                e.due = cyc + 2;
                e.rgb = expect_px(m_p);
                sb.push_back(e);
                if (m_p < 1023) m_p++;
            end
        end
        if (bufferWe) mem_m[{writeIndex, bufferAddress}] = bufferData;
        @(posedge clock);
        #1;
        reset = 0; bufferWe = 0; lineStart = 0; pixelRequest = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(bit bank, int addr, logic [31:0] d);
        writeIndex = bank; bufferAddress = 9'(addr); bufferData = d; bufferWe = 1;
        step();
    endtask

    task automatic start_line(int w, bit dual, bit gray, bit act, bit with_req);
        graphicsWidth = 10'(w); dualPixel = dual; grayscale = gray; lineActive = act;
        lineStart = 1; pixelRequest = with_req;
        step();
    endtask

    task automatic reqs(int n, int gap_max, bit rnd_wr);
        for (int i = 0; i < n; i++) begin
            pixelRequest = 1;
            if (rnd_wr && $urandom_range(0, 3) == 0) begin
                bufferWe = 1; bufferAddress = 9'($urandom); bufferData = $urandom;
            end
            step();
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (pixelValid !== 1'b1 || {red, green, blue} !== e.rgb) begin
                errors++;
                $display("FAIL pixel cyc=%0d valid=%b rgb=%06h required valid=1 rgb=%06h",
                         cyc, pixelValid, {red, green, blue}, e.rgb);
            end else begin
                $display("pixel cyc=%0d rgb=%06h ok", cyc, {red, green, blue});
            end
        end else begin
            checks++;
            if (pixelValid !== 1'b0 || {red, green, blue} !== 24'h0) begin
                errors++;
                $display("FAIL idle cyc=%0d valid=%b rgb=%06h required valid=0 rgb=000000",
                         cyc, pixelValid, {red, green, blue});
            end
        end
    end

    initial begin
        reset = 1; step();
        reset = 1; step();
        idle(2);
        for (int i = 0; i < 1024; i++) wr(i / 512, i % 512, $urandom);

        // RGB565 primaries from bank 0
        wr(0, 0, 32'hF800_07E0);
        wr(0, 1, 32'h001F_FFFF);
        writeIndex = 1;
        start_line(4, 0, 0, 1, 0);
        reqs(4, 0, 0);
        idle(3);

        // Gray with doubling from bank 1
        wr(1, 0, 32'h0010_80FF);
        writeIndex = 0;
        start_line(8, 1, 1, 1, 0);
        reqs(8, 0, 0);
        idle(3);

        // Width boundary and inactive line
        writeIndex = 1;
        start_line(3, 0, 0, 1, 0);
        reqs(5, 0, 0);
        start_line(4, 0, 0, 0, 0);
        reqs(4, 0, 0);
        idle(3);

        // Ping-pong: bank0 white, bank1 black, writeIndex toggled mid-line
        for (int i = 0; i < 32; i++) begin
            wr(0, i, 32'hFFFF_FFFF);
            wr(1, i, 32'h0);
        end
        for (int l = 0; l < 4; l++) begin
            writeIndex = l[0] ? 1'b0 : 1'b1;
            start_line(32, 0, 0, 1, 0);
            reqs(16, 0, 0);
            writeIndex = ~writeIndex;
            reqs(16, 0, 0);
            idle(2);
        end

        // lineStart with request, then a saturating burst
        writeIndex = 1;
        start_line(640, 0, 0, 1, 1);
        reqs(1100, 0, 0);
        idle(3);

        // Reset one cycle after a request, then recovery
        start_line(16, 0, 0, 1, 0);
        pixelRequest = 1; step();
        reset = 1; step();
        idle(3);
        writeIndex = 1;
        start_line(16, 0, 0, 1, 1);
        reqs(3, 0, 0);
        idle(3);

        // Randomised lines with concurrent DMA writes and bank toggles
        for (int l = 0; l < 12; l++) begin
            writeIndex = 1'($urandom);
            start_line($urandom_range(0, 1023), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 5) != 0, 1'($urandom));
            if ($urandom_range(0, 1)) writeIndex = ~writeIndex;
            reqs($urandom_range(0, 700), $urandom_range(0, 2), 1);
            idle($urandom_range(0, 4));
        end

        idle(5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_line_reader.md
Name: pixel_line_reader

Overview:
- Line buffer downstream of the graphics DMA controller.
- Stores the 32-bit words the DMA controller writes into a two-bank (ping-pong) line memory.
- On the video side, one clock domain, it unpacks RGB565 or 8-bit grayscale pixels, applies horizontal pixel doubling and expands them to 24-bit RGB for the HDMI encoder.
- Pixels outside the active graphics area are black.

Parameters:
- bankDepthLog2, 9, log2 of words per bank (512 words, 32-bit each).
- maxWidth, 640, maximum output pixels per line; widths above this are clamped.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- bufferWe  input  1  write strobe from DMA controller
- bufferAddress  input  9  word address within the bank being written
- bufferData  input  32  pixel word to store
- writeIndex  input  1  bank currently being filled by the DMA controller
- graphicsWidth  input  10  active width in output pixels (already doubled when dualPixel)
- dualPixel  input  1  each source pixel is shown twice horizontally
- grayscale  input  1  1: 8 bpp gray, 0: RGB565
- lineActive  input  1  current video line lies inside the graphics height
- lineStart  input  1  one-cycle pulse before the first pixelRequest of each line
- pixelRequest  input  1  one output pixel requested this cycle
- pixelValid  output  1  red/green/blue hold a requested pixel
- red  output  8  red component
- green  output  8  green component
- blue  output  8  blue component

Behaviour:
- Memory: 2 x 512 x 32. Write port address is {writeIndex, bufferAddress}, written when bufferWe=1. Read port is synchronous and registered.
- Same bank and address written and read in one cycle: the read returns the old data (read-before-write). The design never relies on this.
- lineStart latches:
  - readBank <= ~writeIndex (the bank the DMA finished last);
  - widthReg <= min(graphicsWidth, maxWidth);
  - dualReg, grayReg, activeReg;
  - pixel counter p <= 0.
- Configuration is therefore frozen for the whole line. Mid-line changes take effect at the next lineStart.
- Source index: s = dualReg ? p>>1 : p.
- Word address:
  - RGB: s>>1; halfword select s[0], 0 -> bits 31:16, 1 -> bits 15:0.
  - Gray: s>>2; byte select s[1:0], 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
- Pipeline, latency exactly 2 cycles:
  - Cycle N: pixelRequest=1; the address is formed from p, and the select bits and blank flag are captured. blank = (p >= widthReg) or ~activeReg.
  - Cycle N+1: RAM word available.
  - Cycle N+2: red/green/blue/pixelValid registered outputs valid.
- p increments by 1 per pixelRequest and saturates at 1023 (no wrap).
- lineStart and pixelRequest in the same cycle: the request uses p=0, and p becomes 1.
- Back-to-back requests are supported every cycle.
- pixelValid is the 2-cycle delayed pixelRequest. When it is 0, the RGB outputs are 0.
- Colour expansion:
  - RGB565: r5=hw[15:11], g6=hw[10:5], b5=hw[4:0]. red={r5,r5[4:2]}, green={g6,g6[5:4]}, blue={b5,b5[4:2]}.
  - Gray: red=green=blue=byte.
  - blank: all 0, pixelValid still 1.
- Reset: pixelValid=0, red=green=blue=0, p=0, readBank=1, widthReg=0, dualReg=grayReg=activeReg=0, pipeline flags cleared.
  - Reset mid-line: pipeline is flushed and no pixelValid appears in the following 2 cycles.
  - Memory contents are not cleared. The DMA controller writes black when disabled.

Test Plan:
- RGB565, width 4, no doubling: write bank0 word0=0xF800_07E0, word1=0x001F_FFFF, writeIndex=1. lineStart, then 4 requests -> pixels (FF,00,00), (00,FF,00), (00,00,FF), (FF,FF,FF), each 2 cycles after its request.
- Gray, dual, width 8: bank1 word0=0x0010_80FF, writeIndex=0. 8 requests -> gray 00,00,10,10,80,80,FF,FF.
- Width 3, 5 requests -> pixels 4 and 5 are (0,0,0) with pixelValid=1. With lineActive=0, all pixels are black.
- Bank ping-pong: bank0 filled with 0xFFFF_FFFF, bank1 with 0. Toggle writeIndex between lines -> alternating white and black lines. A writeIndex change mid-line does not change the current line's output.
- lineStart coinciding with pixelRequest -> output is pixel 0. A 1100-request burst -> counter saturates and all outputs past the width are black; no wrap to pixel 0.
- Reset asserted one cycle after a request -> pixelValid stays 0. After release, a lineStart plus request yields correct pixel 0 at latency 2.
